imm_encoder: RTL and testbench
==============================

# imm_encoder

Pipelined immediate packer: the inverse of the extend unit. It takes a base instruction word, a 32-bit immediate and an `immsrc` code, and places the immediate into the I/S/B/J bit positions of the instruction. It also flags any immediate that the format cannot represent. It sits between the program loader/patcher and instruction memory write port, so the loader can relocate branch and jump offsets and patch load/store offsets. For every non-error result, feeding `out_instr[31:7]` and the same `immsrc` back through the extend unit must return `in_imm` exactly.

## Interface
Parameters
- `CNT_W`, default 16: width of the wrapping encoded-instruction counter.
- `ERR_W`, default 8: width of the saturating error counter.

Ports
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: block can accept a beat (combinational).
- `in_instr`, input, 32: base instruction; opcode, rd, rs1, rs2 and funct fields are preserved.
- `in_imm`, input, 32: immediate to encode, two's complement.
- `immsrc`, input, 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `out_valid`, output, 1: output beat valid.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_instr`, output, 32: packed instruction.
- `out_err`, output, 1: immediate not representable in the selected format.
- `enc_count`, output, `CNT_W`: number of output transfers; wraps.
- `err_count`, output, `ERR_W`: number of output transfers with `out_err` = 1; saturates at all-ones.

## Operation
Packing clears the immediate field bits of `in_instr` and ORs in the immediate:
- I: bits[31:20] = imm[11:0].
- S: bits[31:25] = imm[11:5]; bits[11:7] = imm[4:0].
- B: bit[31] = imm[12]; bits[30:25] = imm[10:5]; bits[11:8] = imm[4:1]; bit[7] = imm[11].
- J: bit[31] = imm[20]; bits[30:21] = imm[10:1]; bit[20] = imm[11]; bits[19:12] = imm[19:12].

Range check:
- I and S: error unless imm[31:11] are all equal.
- B: error unless imm[31:12] are all equal and imm[0] = 0.
- J: error unless imm[31:20] are all equal and imm[0] = 0.
- On error the bits are still packed from the truncated immediate, and `out_err` = 1.

Pipeline:
- Two register stages. S1 captures `in_instr`, `in_imm` and `immsrc`, and computes the range-check result. S2 holds the packed word and the error flag, and drives the outputs.
- S2 advances when `!s2_valid || out_ready`.
- S1 advances into S2 when S1 is valid and S2 advances.
- `in_ready` = `!s1_valid || s1_advance`.
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.

Counters:
- On every output transfer, `enc_count` increments modulo 2^`CNT_W`.
- If that transfer has `out_err` = 1, `err_count` also increments, holding at 2^`ERR_W`-1 once reached.

## Timing
- Reset values: `out_valid` 0, `out_instr` 0, `out_err` 0, `enc_count` 0, `err_count` 0. Both stage valid bits are 0, so `in_ready` = 1 in the first cycle after reset.
- Latency: an input accepted at edge N appears on the outputs after edge N+1, i.e. 2 cycles when unstalled.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- Output stability: `out_instr` and `out_err` hold stable while `out_valid && !out_ready`.
- Stall capacity: with `out_ready` held low, exactly 2 beats are accepted, then `in_ready` = 0 until the next output transfer.
- Simultaneous accept and drain: with both stages full and `out_ready` = 1, a new input is accepted in the same cycle (`in_ready` = 1). No bubble, no drop, no duplicate.
- Reset mid-operation: `reset` = 1 on any edge clears both stage valid bits and both counters, discarding in-flight beats. Input presented in the reset cycle is not accepted.
- Inputs are sampled only on an input transfer. Changing `in_*` while `in_ready` = 0 has no effect.

## Test plan
1. I-type: `in_instr`=0x00000013, `in_imm`=0xFFFFFFFF, `immsrc`=00 -> 2 cycles later `out_instr`=0xFFF00013, `out_err`=0, `enc_count`=1 after the transfer.
2. S-type and B-type, back-to-back beats:
   - S: 0x00002023, imm 0x7FF -> 0x7E002FA3.
   - B: 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3, on consecutive cycles.
   - J: 0x0000006F, imm 8 -> 0x0080006F.
   - Each result round-trips through the extend unit to the original immediate.
3. Errors:
   - B-type imm 0x00001000 -> `out_err`=1.
   - B-type imm 3 -> `out_err`=1.
   - I-type imm 0x00000800 -> `out_err`=1.
   - After these 3 transfers, `err_count`=3.
   - Force `err_count` to 0xFF -> it stays 0xFF on further errors.
4. Backpressure:
   - Hold `out_ready`=0 and offer 3 beats -> 2 accepted, `in_ready`=0, `out_instr` stable.
   - Raise `out_ready` -> beats emerge in order, third accepted, no loss or duplication.
5. Reset mid-flight: assert `reset` with both stages full -> next cycle `out_valid`=0, both counters=0, `in_ready`=1, and no stale beat ever emerges.
6. Wrap: with `CNT_W`=4, perform 17 transfers -> `enc_count`=1.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Handshake bundle for the immediate packer: input beat (instr/imm/format)
// and output beat (packed instr/error flag), each with valid/ready.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_imm;
    logic [1:0]  immsrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    // Producer of input beats / consumer of output beats.
    modport master (
        output in_valid, in_instr, in_imm, immsrc, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    // The packer itself.
    modport slave (
        input  in_valid, in_instr, in_imm, immsrc, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate packer: places a 32-bit immediate into the I/S/B/J
// field positions of a base instruction and flags immediates the selected
// format cannot represent. Counts output transfers and erroneous ones.
module imm_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0]       SRC_I   = 2'b00;
    localparam logic [1:0]       SRC_S   = 2'b01;
    localparam logic [1:0]       SRC_B   = 2'b10;
    localparam logic [1:0]       SRC_J   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Clear the immediate field of the format and insert the (truncated) immediate.
    function automatic logic [31:0] f_pack(input logic [31:0] instr,
                                           input logic [31:0] imm,
                                           input logic [1:0]  src);
        logic [31:0] w;
        w = instr;
        case (src)
            SRC_I:   w = {imm[11:0], instr[19:0]};
            SRC_S:   w = {imm[11:5], instr[24:12], imm[4:0], instr[6:0]};
            SRC_B:   w = {imm[12], imm[10:5], instr[24:12], imm[4:1], imm[11], instr[6:0]};
            SRC_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], instr[11:0]};
            default: w = instr;
        endcase
        return w;
    endfunction

    // True when the immediate does not survive a pack/extend round trip.
    function automatic logic f_range_err(input logic [31:0] imm,
                                         input logic [1:0]  src);
        logic e;
        e = 1'b0;
        case (src)
            SRC_I, SRC_S: e = !((&imm[31:11]) || !(|imm[31:11]));
            SRC_B:        e = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            SRC_J:        e = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:      e = 1'b1;
        endcase
        return e;
    endfunction

    logic        r_s1_valid;
    logic [31:0] r_s1_instr;
    logic [31:0] r_s1_imm;
    logic [1:0]  r_s1_src;
    logic        r_s1_err;
    logic        r_s2_valid;
    logic [31:0] r_s2_instr;
    logic        r_s2_err;
    logic [CNT_W-1:0] r_enc_count;
    logic [ERR_W-1:0] r_err_count;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_in_xfer;
    logic w_out_xfer;

    // Handshake: S2 frees when empty or drained; S1 moves on when S2 frees.
    always_comb begin
        w_s2_adv   = !r_s2_valid || bus.out_ready;
        w_s1_adv   = r_s1_valid && w_s2_adv;
        w_in_ready = !r_s1_valid || w_s1_adv;
        w_in_xfer  = bus.in_valid && w_in_ready;
        w_out_xfer = r_s2_valid && bus.out_ready;
    end

    // Stage 1: capture the input beat and its range-check result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= 32'h0000_0000;
            r_s1_imm   <= 32'h0000_0000;
            r_s1_src   <= 2'b00;
            r_s1_err   <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_instr <= bus.in_instr;
            r_s1_imm   <= bus.in_imm;
            r_s1_src   <= bus.immsrc;
            r_s1_err   <= f_range_err(bus.in_imm, bus.immsrc);
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: packed word and error flag; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= 32'h0000_0000;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= f_pack(r_s1_instr, r_s1_imm, r_s1_src);
                r_s2_err   <= r_s1_err;
            end
        end
    end

    // Transfer counters: encoded beats wrap, error beats saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enc_count <= {CNT_W{1'b0}};
            r_err_count <= {ERR_W{1'b0}};
        end else if (w_out_xfer) begin
            r_enc_count <= r_enc_count + CNT_ONE;
            if (r_s2_err && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_ONE;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_instr = r_s2_instr;
    assign bus.out_err   = r_s2_err;
    assign enc_count     = r_enc_count;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: default instance for function, latency,
// backpressure and reset; a CNT_W=4/ERR_W=2 instance for wrap and saturation.
module tb_imm_encoder;

    logic clk;
    logic reset;
    logic [3:0]  b_enc;
    logic [1:0]  b_err;
    logic [15:0] a_enc;
    logic [7:0]  a_err;

    int checks;
    int failures;

    imm_encoder_if a_if ();
    imm_encoder_if b_if ();

    imm_encoder #(.CNT_W(16), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if), .enc_count(a_enc), .err_count(a_err)
    );

    imm_encoder #(.CNT_W(4), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if), .enc_count(b_enc), .err_count(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream vectors for the back-to-back sections.
    logic [31:0] v_instr [8];
    logic [31:0] v_imm   [8];
    logic [1:0]  v_src   [8];
    logic [31:0] v_exp   [8];
    logic        v_err   [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference extend unit (instruction word -> sign-extended immediate).
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] src);
        case (src)
            2'b00:   return {{20{w[31]}}, w[31:20]};
            2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
            2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    // Push n vectors back-to-back into instance A with out_ready=1 and check
    // each output exactly two cycles after its input was offered.
    task automatic stream_a(input int n);
        for (int c = 0; c < n + 2; c++) begin
            if (c >= 2) begin
                chk("stream_valid", {31'd0, a_if.out_valid}, 32'd1);
                chk("stream_instr", a_if.out_instr, v_exp[c-2]);
                chk("stream_err", {31'd0, a_if.out_err}, {31'd0, v_err[c-2]});
                if (!v_err[c-2])
                    chk("stream_roundtrip", extend(a_if.out_instr, v_src[c-2]), v_imm[c-2]);
            end
            if (c < n) begin
                a_if.in_valid = 1'b1;
                a_if.in_instr = v_instr[c];
                a_if.in_imm   = v_imm[c];
                a_if.immsrc   = v_src[c];
            end else begin
                a_if.in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_instr = 32'd0; a_if.in_imm = 32'd0;
        a_if.immsrc = 2'b00; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_instr = 32'd0; b_if.in_imm = 32'd0;
        b_if.immsrc = 2'b00; b_if.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
        chk("rst_out_instr", a_if.out_instr, 32'd0);
        chk("rst_out_err", {31'd0, a_if.out_err}, 32'd0);
        chk("rst_enc", {16'd0, a_enc}, 32'd0);
        chk("rst_err", {24'd0, a_err}, 32'd0);
        chk("rst_in_ready", {31'd0, a_if.in_ready}, 32'd1);

        // 1: I-type, latency 2
        a_if.in_valid = 1'b1; a_if.in_instr = 32'h0000_0013;
        a_if.in_imm = 32'hFFFF_FFFF; a_if.immsrc = 2'b00;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        chk("i_lat_not_yet", {31'd0, a_if.out_valid}, 32'd0);
        @(negedge clk);
        chk("i_valid", {31'd0, a_if.out_valid}, 32'd1);
        chk("i_instr", a_if.out_instr, 32'hFFF0_0013);
        chk("i_err", {31'd0, a_if.out_err}, 32'd0);
        @(negedge clk);
        chk("i_enc", {16'd0, a_enc}, 32'd1);
        chk("i_drained", {31'd0, a_if.out_valid}, 32'd0);

        // 2: S, B, J back-to-back
        v_instr[0] = 32'h0000_2023; v_imm[0] = 32'h0000_07FF; v_src[0] = 2'b01; v_exp[0] = 32'h7E00_2FA3; v_err[0] = 1'b0;
        v_instr[1] = 32'h0000_0063; v_imm[1] = 32'hFFFF_FFFC; v_src[1] = 2'b10; v_exp[1] = 32'hFE00_0EE3; v_err[1] = 1'b0;
        v_instr[2] = 32'h0000_006F; v_imm[2] = 32'h0000_0008; v_src[2] = 2'b11; v_exp[2] = 32'h0080_006F; v_err[2] = 1'b0;
        stream_a(3);
        chk("sbj_enc", {16'd0, a_enc}, 32'd4);

        // 3: unrepresentable immediates
        v_instr[0] = 32'h0000_0063; v_imm[0] = 32'h0000_1000; v_src[0] = 2'b10; v_exp[0] = 32'h8000_0063; v_err[0] = 1'b1;
        v_instr[1] = 32'h0000_0063; v_imm[1] = 32'h0000_0003; v_src[1] = 2'b10; v_exp[1] = 32'h0000_0163; v_err[1] = 1'b1;
        v_instr[2] = 32'h0000_0013; v_imm[2] = 32'h0000_0800; v_src[2] = 2'b00; v_exp[2] = 32'h8000_0013; v_err[2] = 1'b1;
        stream_a(3);
        chk("err_enc", {16'd0, a_enc}, 32'd7);
        chk("err_count3", {24'd0, a_err}, 32'd3);

        // 4: backpressure, three beats offered with out_ready low
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_instr = 32'h0000_0013; a_if.in_imm = 32'h0000_0005; a_if.immsrc = 2'b00;
        @(negedge clk);
        chk("bp_ready1", {31'd0, a_if.in_ready}, 32'd1);
        a_if.in_instr = 32'h0000_2023; a_if.in_imm = 32'hFFFF_FFFC; a_if.immsrc = 2'b01;
        @(negedge clk);
        chk("bp_full_ready", {31'd0, a_if.in_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, a_if.out_valid}, 32'd1);
        chk("bp_hold_instr", a_if.out_instr, 32'h0050_0013);
        a_if.in_instr = 32'h0000_006F; a_if.in_imm = 32'hFFFF_FFFE; a_if.immsrc = 2'b11;
        @(negedge clk);
        chk("bp_still_full", {31'd0, a_if.in_ready}, 32'd0);
        chk("bp_stable_instr", a_if.out_instr, 32'h0050_0013);
        chk("bp_stable_err", {31'd0, a_if.out_err}, 32'd0);
        chk("bp_enc_held", {16'd0, a_enc}, 32'd7);
        a_if.out_ready = 1'b1;
        #1;
        chk("bp_accept_drain", {31'd0, a_if.in_ready}, 32'd1);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        chk("bp_out1", a_if.out_instr, 32'hFE00_2E23);
        @(negedge clk);
        chk("bp_out2_valid", {31'd0, a_if.out_valid}, 32'd1);
        chk("bp_out2", a_if.out_instr, 32'hFFFF_F06F);
        chk("bp_out2_rt", extend(a_if.out_instr, 2'b11), 32'hFFFF_FFFE);
        @(negedge clk);
        chk("bp_no_dup", {31'd0, a_if.out_valid}, 32'd0);
        chk("bp_enc", {16'd0, a_enc}, 32'd10);

        // 5: reset with both stages full
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_instr = 32'h0000_0013; a_if.in_imm = 32'h0000_0800; a_if.immsrc = 2'b00;
        @(negedge clk);
        a_if.in_instr = 32'h0000_0013; a_if.in_imm = 32'h0000_0001;
        @(negedge clk);
        chk("rm_full", {31'd0, a_if.in_ready}, 32'd0);
        reset = 1'b1;
        a_if.out_ready = 1'b1;
        a_if.in_instr = 32'h0000_0013; a_if.in_imm = 32'h0000_0002;
        @(negedge clk);
        reset = 1'b0;
        a_if.in_valid = 1'b0;
        chk("rm_valid", {31'd0, a_if.out_valid}, 32'd0);
        chk("rm_enc", {16'd0, a_enc}, 32'd0);
        chk("rm_err", {24'd0, a_err}, 32'd0);
        chk("rm_in_ready", {31'd0, a_if.in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rm_no_stale", {31'd0, a_if.out_valid}, 32'd0);
        end
        chk("rm_enc_after", {16'd0, a_enc}, 32'd0);

        // 6: wrap and saturation on the narrow instance (all beats in error)
        b_if.in_valid = 1'b1; b_if.in_instr = 32'h0000_0013; b_if.in_imm = 32'h0000_0800; b_if.immsrc = 2'b00;
        repeat (3) @(negedge clk);
        b_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("w_enc3", {28'd0, b_enc}, 32'd3);
        chk("w_err_sat", {30'd0, b_err}, 32'd3);
        b_if.in_valid = 1'b1;
        @(negedge clk);
        b_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("w_err_hold", {30'd0, b_err}, 32'd3);
        b_if.in_valid = 1'b1;
        repeat (13) @(negedge clk);
        b_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("w_enc_wrap", {28'd0, b_enc}, 32'd1);
        chk("w_err_final", {30'd0, b_err}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
